// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard and branch-resolution controller for the
// 5-stage MIPS pipeline. It detects load-use and branch operand hazards against
// the EX and MEM destinations, holds multi-cycle stalls in a small FSM, and
// redirects the PC for taken beq/bne using the decode-stage equality flag.
//
// Optional feature macro: FLUSH_CNT_EN (builds the taken-branch flush counter;
// when undefined, flush_count is tied to zero).
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   id_opcode/id_rs/id_rt    fields of the IF/ID instruction
//   id_zero                  decode comparator, read_data1 == read_data2
//   ex_reg_write/ex_mem_read/ex_dest   EX-stage writeback info
//   mem_mem_read/mem_dest    MEM-stage load info
//   pc_write, ifid_write     PC and IF/ID load enables
//   ifid_flush, idex_bubble  IF/ID clear, ID/EX nop insert
//   pc_src                   1 = branch target, 0 = PC+4
//   stall_count, flush_count saturating event counters
module id_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_zero,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_dest,
   input  logic             mem_mem_read,
   input  logic [4:0]       mem_dest,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pc_src,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic             rem_q, rem_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic       is_beq, is_bne, is_br, uses_rt;
   logic       ex_match, mem_match;
   logic [1:0] need_n;
   logic       stall_c, taken_c;

   // Opcode decode and operand matching; register 0 never matches.
   always_comb begin
      is_beq    = (id_opcode == OP_BEQ);
      is_bne    = (id_opcode == OP_BNE);
      is_br     = is_beq || is_bne;
      uses_rt   = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) || is_br;
      ex_match  = (ex_dest != 5'd0) &&
                  ((ex_dest == id_rs) || (uses_rt && (ex_dest == id_rt)));
      mem_match = (mem_dest != 5'd0) &&
                  ((mem_dest == id_rs) || (uses_rt && (mem_dest == id_rt)));
   end

   // Stall requirement; first matching rule wins.
   always_comb begin
      need_n = 2'd0;
      if (is_br && ex_match && ex_mem_read)
         need_n = 2'd2;
      else if (is_br && ex_match && ex_reg_write)
         need_n = 2'd1;
      else if (is_br && mem_match && mem_mem_read)
         need_n = 2'd1;
      else if (!is_br && ex_match && ex_mem_read)
         need_n = 2'd1;
   end

   // Next state; a stall always masks the branch, which is re-evaluated later.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      stall_c = 1'b0;
      taken_c = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (need_n != 2'd0) begin
               stall_c = 1'b1;
               if (need_n == 2'd2) begin
                  state_d = ST_HOLD;
                  rem_d   = 1'b1;
               end
            end else begin
               taken_c = (is_beq && id_zero) || (is_bne && !id_zero);
            end
         end
         ST_HOLD: begin
            stall_c = 1'b1;
            rem_d   = rem_q - 1'b1;
            if (rem_d == 1'b0)
               state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Saturating stall counter.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_c && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         rem_q       <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Control outputs are combinational; reset forces the idle values.
   assign pc_write    = rst | ~stall_c;
   assign ifid_write  = rst | ~stall_c;
   assign idex_bubble = ~rst & stall_c;
   assign pc_src      = ~rst & taken_c;
   assign ifid_flush  = ~rst & taken_c;
   assign stall_count = stall_cnt_q;

`ifdef FLUSH_CNT_EN
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating count of cycles with ifid_flush asserted.
   always_comb begin
      flush_cnt_d = flush_cnt_q;
      if (taken_c && !(&flush_cnt_q))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flush_cnt_q <= '0;
      else
         flush_cnt_q <= flush_cnt_d;
   end

   assign flush_count = flush_cnt_q;
`else
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl. A narrow counter width makes saturation
// reachable in a few cycles.
module tb_id_hazard_ctrl;

   localparam int unsigned TB_CNT_W = 4;
   localparam logic [4:0]  CTL_IDLE  = 5'b11000; // pc_write,ifid_write,ifid_flush,idex_bubble,pc_src
   localparam logic [4:0]  CTL_STALL = 5'b00010;
   localparam logic [4:0]  CTL_TAKEN = 5'b11101;
`ifdef FLUSH_CNT_EN
   localparam bit FLUSH_ON = 1'b1;
`else
   localparam bit FLUSH_ON = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [5:0]          id_opcode;
   logic [4:0]          id_rs, id_rt;
   logic                id_zero;
   logic                ex_reg_write, ex_mem_read;
   logic [4:0]          ex_dest;
   logic                mem_mem_read;
   logic [4:0]          mem_dest;
   logic                pc_write, ifid_write, ifid_flush, idex_bubble, pc_src;
   logic [TB_CNT_W-1:0] stall_count, flush_count;
   logic [4:0]          ctl;
   logic [TB_CNT_W-1:0] exp_flush;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pc_src};

   id_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_opcode    (id_opcode),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_zero      (id_zero),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_dest      (ex_dest),
      .mem_mem_read (mem_mem_read),
      .mem_dest     (mem_dest),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .pc_src       (pc_src),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic zero, input logic exrw, input logic exmr,
                         input logic [4:0] exd, input logic memmr, input logic [4:0] memd);
      id_opcode = op; id_rs = rs; id_rt = rt; id_zero = zero;
      ex_reg_write = exrw; ex_mem_read = exmr; ex_dest = exd;
      mem_mem_read = memmr; mem_dest = memd;
   endtask

   task automatic set_nop();
      set_in(6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      // Hazard present while in reset: outputs must still be idle.
      set_in(6'h00, 5'd3, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
      tick(); tick();
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_IDLE); end
      total++;
      if (stall_count !== 4'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_count); end
      total++;
      if (flush_count !== 4'd0) begin bad++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_count); end
      rst = 1'b0;
      set_nop();
      tick();
   endtask

   task automatic test_load_use();
      do_reset();
      // R-type reads rt=8 while lw to $8 is in EX.
      set_in(6'h00, 5'd3, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL loaduse_stall got=%b exp=%b", ctl, CTL_STALL); end
      tick();
      // Bubble now in EX, load in MEM: no stall for a non-branch.
      set_in(6'h00, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL loaduse_after got=%b exp=%b", ctl, CTL_IDLE); end
      total++;
      if (stall_count !== 4'd1) begin bad++; $display("FAIL loaduse_cnt got=%0d exp=1", stall_count); end
      tick();
      total++;
      if (stall_count !== 4'd1) begin bad++; $display("FAIL loaduse_cnt_hold got=%0d exp=1", stall_count); end
      set_nop();
   endtask

   task automatic test_branch_after_lw();
      do_reset();
      set_in(6'h04, 5'd9, 5'd4, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL brlw_run_stall got=%b exp=%b", ctl, CTL_STALL); end
      tick();
      // In HOLD: hazard-free taken-branch inputs must be ignored.
      set_in(6'h04, 5'd9, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL brlw_hold_stall got=%b exp=%b", ctl, CTL_STALL); end
      total++;
      if (stall_count !== 4'd1) begin bad++; $display("FAIL brlw_cnt1 got=%0d exp=1", stall_count); end
      tick();
      #1;
      total++;
      if (ctl !== CTL_TAKEN) begin bad++; $display("FAIL brlw_taken got=%b exp=%b", ctl, CTL_TAKEN); end
      total++;
      if (stall_count !== 4'd2) begin bad++; $display("FAIL brlw_cnt2 got=%0d exp=2", stall_count); end
      tick();
      set_nop();
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL brlw_after got=%b exp=%b", ctl, CTL_IDLE); end
      exp_flush = FLUSH_ON ? 4'd1 : 4'd0;
      total++;
      if (flush_count !== exp_flush) begin bad++; $display("FAIL brlw_flush_cnt got=%0d exp=%0d", flush_count, exp_flush); end
   endtask

   task automatic test_branch_resolve();
      do_reset();
      // bne, operands differ, no hazard: redirect immediately.
      set_in(6'h05, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_TAKEN) begin bad++; $display("FAIL bne_taken got=%b exp=%b", ctl, CTL_TAKEN); end
      tick();
      exp_flush = FLUSH_ON ? 4'd1 : 4'd0;
      total++;
      if (flush_count !== exp_flush) begin bad++; $display("FAIL bne_flush_cnt got=%0d exp=%0d", flush_count, exp_flush); end
      // bne with equal operands, beq with unequal operands: fall through.
      set_in(6'h05, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL bne_not_taken got=%b exp=%b", ctl, CTL_IDLE); end
      set_in(6'h04, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL beq_not_taken got=%b exp=%b", ctl, CTL_IDLE); end
      total++;
      if (stall_count !== 4'd0) begin bad++; $display("FAIL br_no_stall_cnt got=%0d exp=0", stall_count); end
   endtask

   task automatic test_branch_alu();
      do_reset();
      // beq reads rt=5 produced by an ALU op in EX: one stall.
      set_in(6'h04, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL bralu_stall got=%b exp=%b", ctl, CTL_STALL); end
      tick();
      set_in(6'h04, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5);
      #1;
      total++;
      if (ctl !== CTL_TAKEN) begin bad++; $display("FAIL bralu_taken got=%b exp=%b", ctl, CTL_TAKEN); end
      tick();
      // beq reads rs=6 while a load to $6 is in MEM: one stall.
      set_in(6'h04, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6);
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL brmem_stall got=%b exp=%b", ctl, CTL_STALL); end
      tick();
      total++;
      if (stall_count !== 4'd2) begin bad++; $display("FAIL brmem_cnt got=%0d exp=2", stall_count); end
      set_nop();
   endtask

   task automatic test_no_hazard_cases();
      do_reset();
      // Register 0 never stalls.
      set_in(6'h00, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL zero_reg got=%b exp=%b", ctl, CTL_IDLE); end
      // lw does not read rt, so an rt match is not a hazard.
      set_in(6'h23, 5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL lw_rt_nohaz got=%b exp=%b", ctl, CTL_IDLE); end
      // sw does read rt.
      set_in(6'h2B, 5'd1, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL sw_rt_haz got=%b exp=%b", ctl, CTL_STALL); end
      set_nop();
      tick();
      total++;
      if (stall_count !== 4'd0) begin bad++; $display("FAIL nohaz_cnt got=%0d exp=0", stall_count); end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      set_in(6'h04, 5'd9, 5'd4, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
      tick();
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL rsthold_pre got=%b exp=%b", ctl, CTL_STALL); end
      rst = 1'b1;
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL rsthold_idle got=%b exp=%b", ctl, CTL_IDLE); end
      total++;
      if (stall_count !== 4'd0) begin bad++; $display("FAIL rsthold_cnt got=%0d exp=0", stall_count); end
      set_nop();
      rst = 1'b0;
      #1;
      total++;
      if (ctl !== CTL_IDLE) begin bad++; $display("FAIL rsthold_run got=%b exp=%b", ctl, CTL_IDLE); end
      tick();
      set_in(6'h00, 5'd8, 5'd2, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
      #1;
      total++;
      if (ctl !== CTL_STALL) begin bad++; $display("FAIL rsthold_resume got=%b exp=%b", ctl, CTL_STALL); end
      tick();
      total++;
      if (stall_count !== 4'd1) begin bad++; $display("FAIL rsthold_resume_cnt got=%0d exp=1", stall_count); end
      set_nop();
   endtask

   task automatic test_saturation();
      do_reset();
      set_in(6'h00, 5'd8, 5'd2, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
      for (int i = 0; i < 14; i++) tick();
      total++;
      if (stall_count !== 4'd14) begin bad++; $display("FAIL sat_pre got=%0d exp=14", stall_count); end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (stall_count !== 4'd15) begin bad++; $display("FAIL sat_hold%0d got=%0d exp=15", i, stall_count); end
      end
      set_nop();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load_use();
      test_branch_after_lw();
      test_branch_resolve();
      test_branch_alu();
      test_no_hazard_cases();
      test_reset_mid_hold();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
